// File: rtl/xbar_pkg.sv
// Shared crossbar types: command encodings, slave address width,
// and the response slot carried down the slave delay line.
package xbar_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  function automatic int slave_aw(input int n);
    return 32 - $clog2(n);
  endfunction

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] data;
  } resp_slot_t;

endpackage

// File: rtl/xbar_resp_delay.sv
// Fixed-latency shift line of response slots; the last stage
// is the response presented to the crossbar.
module xbar_resp_delay
  import xbar_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  resp_slot_t din,
  output resp_slot_t dout
);

  resp_slot_t line [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        line[i] <= '0;
    end else begin
      line[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        line[i] <= line[i-1];
    end
  end

  assign dout = line[DEPTH-1];

endmodule

// File: rtl/xbar_slave_mem.sv
// Memory-backed crossbar slave: acks requests, commits writes,
// and returns in-order responses after a fixed latency.
module xbar_slave_mem
  import xbar_pkg::*;
#(
  parameter int N               = 4,
  parameter int MEM_WORDS       = 256,
  parameter int RESP_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 2,
  localparam int AW = slave_aw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          cmd,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          stall,
  output logic          ack,
  output logic          resp,
  output logic [31:0]   rdata
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   mem [MEM_WORDS];
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          accept;
  resp_slot_t    slot_in;
  resp_slot_t    slot_out;
  logic          unused_hi;

  // high address bits alias onto the same storage
  assign idx       = addr[IW-1:0];
  assign unused_hi = ^addr[AW-1:IW];

  assign ack    = req & ~stall &
                  ((cnt < CW'(MAX_OUTSTANDING)) | resp);
  assign accept = req & ack;

  always_comb begin
    slot_in = '0;
    if (accept) begin
      slot_in.valid    = 1'b1;
      slot_in.is_write = cmd;
      slot_in.data     = (cmd == CMD_WRITE) ? 32'h0 : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && cmd == CMD_WRITE)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (accept && !resp)
      cnt <= cnt + 1'b1;
    else if (!accept && resp)
      cnt <= cnt - 1'b1;
  end

  xbar_resp_delay #(
    .DEPTH(RESP_LATENCY)
  ) u_delay (
    .clk (clk),
    .rst (rst),
    .din (slot_in),
    .dout(slot_out)
  );

  assign resp  = slot_out.valid;
  assign rdata = (slot_out.valid && !slot_out.is_write)
               ? slot_out.data : 32'h0;

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Directed bench for xbar_slave_mem: default instance (LAT=2, MO=2)
// and a second instance with LAT=3, MO=1.
module tb_xbar_slave_mem;

  localparam int AW = 30;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqa, cmda, stalla, acka, respa;
  logic [AW-1:0] addra;
  logic [31:0]   wdataa, rdataa;
  logic          reqb, cmdb, stallb, ackb, respb;
  logic [AW-1:0] addrb;
  logic [31:0]   wdatab, rdatab;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xbar_slave_mem #(
    .N(4), .MEM_WORDS(256),
    .RESP_LATENCY(2), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk(clk), .rst(rst), .req(reqa), .cmd(cmda),
    .addr(addra), .wdata(wdataa), .stall(stalla),
    .ack(acka), .resp(respa), .rdata(rdataa)
  );

  xbar_slave_mem #(
    .N(4), .MEM_WORDS(256),
    .RESP_LATENCY(3), .MAX_OUTSTANDING(1)
  ) dut_b (
    .clk(clk), .rst(rst), .req(reqb), .cmd(cmdb),
    .addr(addrb), .wdata(wdatab), .stall(stallb),
    .ack(ackb), .resp(respb), .rdata(rdatab)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic c,
                       input logic [AW-1:0] a,
                       input logic [31:0] d,
                       input logic s);
    reqa = r; cmda = c; addra = a; wdataa = d; stalla = s;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [6:0] ack_pat;
  logic [6:0] resp_pat;

  initial begin
    rst = 1'b1;
    reqa = 0; cmda = 0; addra = '0; wdataa = '0; stalla = 0;
    reqb = 0; cmdb = 0; addrb = '0; wdatab = '0; stallb = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_a",  32'(respa),  32'd0);
    chk("rst_rdata_a", rdataa,      32'd0);
    chk("rst_ack_a",   32'(acka),   32'd0);
    chk("rst_resp_b",  32'(respb),  32'd0);
    rst = 1'b0;
    tick();

    // write then read 0x05
    set_a(1, 1, 30'h05, 32'hDEADBEEF, 0);
    chk("t1_wr_ack",  32'(acka),  32'd1);
    chk("t1_c0_resp", 32'(respa), 32'd0);
    tick();
    set_a(1, 0, 30'h05, 32'h0, 0);
    chk("t1_rd_ack",  32'(acka),  32'd1);
    chk("t1_c1_resp", 32'(respa), 32'd0);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    chk("t1_wr_resp",  32'(respa), 32'd1);
    chk("t1_wr_rdata", rdataa,     32'd0);
    tick();
    chk("t1_rd_resp",  32'(respa), 32'd1);
    chk("t1_rd_rdata", rdataa,     32'hDEADBEEF);
    tick();
    chk("t1_idle_resp",  32'(respa), 32'd0);
    chk("t1_idle_rdata", rdataa,     32'd0);

    // preload 1..3 back to back
    for (int i = 1; i <= 3; i++) begin
      set_a(1, 1, AW'(i), 32'h1111_1111 * i, 0);
      chk($sformatf("pre_ack%0d", i), 32'(acka), 32'd1);
      tick();
    end
    set_a(0, 0, 30'h0, 32'h0, 0);
    repeat (3) tick();

    // three reads with req held
    set_a(1, 0, 30'h01, 32'h0, 0);
    chk("t2_ack0", 32'(acka), 32'd1);
    tick();
    set_a(1, 0, 30'h02, 32'h0, 0);
    chk("t2_ack1",  32'(acka),  32'd1);
    chk("t2_resp1", 32'(respa), 32'd0);
    tick();
    set_a(1, 0, 30'h03, 32'h0, 0);
    chk("t2_ack2",   32'(acka),  32'd1);
    chk("t2_resp2",  32'(respa), 32'd1);
    chk("t2_rdata2", rdataa,     32'h1111_1111);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    chk("t2_resp3",  32'(respa), 32'd1);
    chk("t2_rdata3", rdataa,     32'h2222_2222);
    tick();
    chk("t2_resp4",  32'(respa), 32'd1);
    chk("t2_rdata4", rdataa,     32'h3333_3333);
    tick();
    chk("t2_resp5", 32'(respa), 32'd0);

    // aliasing: 0x105 and 0x005 share a word
    set_a(1, 1, 30'h105, 32'h0000_1234, 0);
    chk("t5_wr_ack", 32'(acka), 32'd1);
    tick();
    set_a(1, 0, 30'h005, 32'h0, 0);
    chk("t5_rd_ack", 32'(acka), 32'd1);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    tick();
    chk("t5_resp",  32'(respa), 32'd1);
    chk("t5_rdata", rdataa,     32'h0000_1234);
    repeat (2) tick();

    // stall holds ack low, pending resp still retires
    set_a(1, 0, 30'h01, 32'h0, 0);
    chk("t4_ack0", 32'(acka), 32'd1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      set_a(1, 0, 30'h02, 32'h0, 1);
      chk($sformatf("t4_stall_ack%0d", c), 32'(acka), 32'd0);
      if (c == 2) begin
        chk("t4_resp",  32'(respa), 32'd1);
        chk("t4_rdata", rdataa,     32'h1111_1111);
      end
      tick();
    end
    set_a(1, 0, 30'h02, 32'h0, 0);
    chk("t4_ack5", 32'(acka), 32'd1);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    chk("t4_resp6", 32'(respa), 32'd0);
    tick();
    chk("t4_resp7",  32'(respa), 32'd1);
    chk("t4_rdata7", rdataa,     32'h2222_2222);
    repeat (2) tick();

    // LAT=3, MO=1 with req held: ack every third cycle
    ack_pat  = 7'b1001001;
    resp_pat = 7'b0001001;
    for (int c = 0; c < 7; c++) begin
      reqb = 1; cmdb = 1; addrb = AW'(c); wdatab = 32'(c);
      #1;
      chk($sformatf("t3_ack%0d", c), 32'(ackb), 32'(ack_pat[6-c]));
      chk($sformatf("t3_resp%0d", c), 32'(respb), 32'(resp_pat[6-c]));
      tick();
    end
    reqb = 0;
    repeat (4) tick();

    // reset drops an in-flight response
    set_a(1, 0, 30'h03, 32'h0, 0);
    chk("t6_ack0", 32'(acka), 32'd1);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_resp", 32'(respa), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_resp2", 32'(respa), 32'd0);
    tick();
    chk("t6_resp3", 32'(respa), 32'd0);
    tick();
    chk("t6_resp4", 32'(respa), 32'd0);
    set_a(1, 0, 30'h03, 32'h0, 0);
    chk("t6_ack_after", 32'(acka), 32'd1);
    tick();
    set_a(0, 0, 30'h0, 32'h0, 0);
    tick();
    chk("t6_resp_after",  32'(respa), 32'd1);
    chk("t6_rdata_after", rdataa,     32'h3333_3333);
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
